// File: rtl/servo_frame_scheduler.sv
// Servo PWM frame scheduler: shared prescaled frame counter, shadow/active pulse widths, bank start/stop sequencing.
// Optional build macro SERVO_SCHED_STAGGER_EN offsets channel i's pulse by i*STAGGER_TICKS inside the frame.
module servo_frame_scheduler #(
  parameter int NUM_CHANNELS        = 4,
  parameter int CHANNEL_INDEX_WIDTH = 2,
  parameter int TICK_DIVIDER        = 50,
  parameter int FRAME_TICKS         = 20000,
  parameter int WIDTH_BITS          = 15,
  parameter int MIN_PULSE           = 1000,
  parameter int MAX_PULSE           = 2000,
  parameter int DEFAULT_PULSE       = 1500,
  parameter int STAGGER_TICKS       = 2500
) (
  input  logic                           SCHED_CLOCK,
  input  logic                           SCHED_RESET_N,
  input  logic                           SCHED_ENABLE,
  input  logic                           WR_VALID,
  output logic                           WR_READY,
  input  logic [CHANNEL_INDEX_WIDTH-1:0] WR_CHANNEL,
  input  logic [WIDTH_BITS-1:0]          WR_WIDTH,
  output logic                           WR_ERROR,
  output logic [NUM_CHANNELS-1:0]        PWM_OUT,
  output logic                           FRAME_START,
  output logic [WIDTH_BITS-1:0]          FRAME_COUNT,
  output logic                           BUSY
);
  // state | meaning
  // IDLE  | bank stopped, counters held at 0, PWM low
  // ALIGN | one-cycle commit of shadow widths ahead of the first frame
  // RUN   | frames running, shadow committed at every frame wrap
  // DRAIN | current frame finishes, then IDLE with no commit
  typedef enum logic [1:0] {IDLE, ALIGN, RUN, DRAIN} state_t;

  localparam int PW = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;

  state_t                  state;
  logic [PW-1:0]           prescale;
  logic [WIDTH_BITS-1:0]   frame_count;
  logic [WIDTH_BITS-1:0]   shadow [NUM_CHANNELS];
  logic [WIDTH_BITS-1:0]   active [NUM_CHANNELS];
  logic                    ready_q;
  logic                    error_q;
  logic                    frame_start_q;
  logic [NUM_CHANNELS-1:0] pwm_q;
  logic [NUM_CHANNELS-1:0] pwm_next;
  logic                    running;
  logic                    tick;
  logic                    wrap;
  logic                    commit;
  logic                    accept;
  logic                    chan_ok;
  logic [WIDTH_BITS-1:0]   width_clamped;

  if (STAGGER_TICKS < 0 || MIN_PULSE > MAX_PULSE || DEFAULT_PULSE < MIN_PULSE ||
      DEFAULT_PULSE > MAX_PULSE || MAX_PULSE >= FRAME_TICKS) begin : g_param_check
    $error("servo_frame_scheduler: inconsistent pulse/frame parameters");
  end

`ifdef SERVO_SCHED_STAGGER_EN
  if ((NUM_CHANNELS - 1) * STAGGER_TICKS + MAX_PULSE > FRAME_TICKS) begin : g_stagger_fit
    $error("servo_frame_scheduler: staggered pulses do not fit in one frame");
  end
`endif

  assign running = (state == RUN) || (state == DRAIN);
  assign tick    = running && (prescale == PW'(TICK_DIVIDER - 1));
  assign wrap    = tick && (frame_count == WIDTH_BITS'(FRAME_TICKS - 1));
  // A wrap in DRAIN ends the bank without committing, so it does not stall writes.
  assign commit  = (state == ALIGN) || ((state == RUN) && wrap);

  assign WR_READY = ready_q && !commit;
  assign accept   = WR_VALID && WR_READY;
  assign chan_ok  = {1'b0, WR_CHANNEL} < (CHANNEL_INDEX_WIDTH + 1)'(NUM_CHANNELS);

  always_comb begin
    width_clamped = WR_WIDTH;
    if (WR_WIDTH < WIDTH_BITS'(MIN_PULSE))
      width_clamped = WIDTH_BITS'(MIN_PULSE);
    else if (WR_WIDTH > WIDTH_BITS'(MAX_PULSE))
      width_clamped = WIDTH_BITS'(MAX_PULSE);
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_pwm
`ifdef SERVO_SCHED_STAGGER_EN
    localparam logic [WIDTH_BITS:0] OFS = (WIDTH_BITS + 1)'((i * STAGGER_TICKS) % FRAME_TICKS);
    localparam logic [WIDTH_BITS:0] FT  = (WIDTH_BITS + 1)'(FRAME_TICKS);
    logic [WIDTH_BITS:0] fc_ext;
    logic [WIDTH_BITS:0] phase;
    assign fc_ext      = {1'b0, frame_count};
    assign phase       = (fc_ext >= OFS) ? (fc_ext - OFS) : (fc_ext + FT - OFS);
    assign pwm_next[i] = phase < {1'b0, active[i]};
`else
    assign pwm_next[i] = frame_count < active[i];
`endif
  end

  always_ff @(posedge SCHED_CLOCK) begin
    if (!SCHED_RESET_N) begin
      state         <= IDLE;
      prescale      <= '0;
      frame_count   <= '0;
      ready_q       <= 1'b0;
      error_q       <= 1'b0;
      frame_start_q <= 1'b0;
      pwm_q         <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow[i] <= WIDTH_BITS'(DEFAULT_PULSE);
        active[i] <= WIDTH_BITS'(DEFAULT_PULSE);
      end
    end else begin
      ready_q       <= 1'b1;
      error_q       <= accept && !chan_ok;
      frame_start_q <= commit;
      pwm_q         <= running ? pwm_next : '0;

      if (accept && chan_ok)
        shadow[WR_CHANNEL] <= width_clamped;
      if (commit)
        for (int i = 0; i < NUM_CHANNELS; i++) active[i] <= shadow[i];

      case (state)
        IDLE: begin
          prescale    <= '0;
          frame_count <= '0;
          if (SCHED_ENABLE) state <= ALIGN;
        end
        ALIGN: begin
          prescale    <= '0;
          frame_count <= '0;
          state       <= RUN;
        end
        RUN, DRAIN: begin
          if (tick) begin
            prescale    <= '0;
            frame_count <= wrap ? '0 : frame_count + 1'b1;
          end else begin
            prescale <= prescale + 1'b1;
          end
          if (state == RUN) begin
            if (!SCHED_ENABLE) state <= DRAIN;
          end else if (SCHED_ENABLE) begin
            state <= RUN;
          end else if (wrap) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign PWM_OUT     = pwm_q;
  assign FRAME_START = frame_start_q;
  assign WR_ERROR    = error_q;
  assign FRAME_COUNT = frame_count;
  assign BUSY        = (state != IDLE);

endmodule

// File: doc/servo_frame_scheduler.md
Name: servo_frame_scheduler

Overview:
- Multi-channel servo PWM sequencer built around a shared prescaled frame counter.
- Accepts per-channel pulse-width writes over a valid/ready port into shadow registers.
- Commits shadow widths to active registers only at frame boundaries, so a pulse is never torn mid-frame.
- Generates one PWM output per channel and sequences start and stop of the whole bank.

Parameters:
- NUM_CHANNELS, 4, number of servo channels
- CHANNEL_INDEX_WIDTH, 2, width of WR_CHANNEL
- TICK_DIVIDER, 50, clock cycles per tick (1 us at 50 MHz)
- FRAME_TICKS, 20000, ticks per PWM frame (20 ms)
- WIDTH_BITS, 15, width of pulse and frame-count values
- MIN_PULSE, 1000, lower clamp in ticks
- MAX_PULSE, 2000, upper clamp in ticks
- DEFAULT_PULSE, 1500, width loaded at reset
- STAGGER_TICKS, 2500, per-channel start offset; used only with SERVO_SCHED_STAGGER_EN

Ports:
- SCHED_CLOCK  in  1  sole clock
- SCHED_RESET_N  in  1  reset, synchronous, active-low
- SCHED_ENABLE  in  1  run request
- WR_VALID  in  1  write request
- WR_READY  out  1  write can be accepted this cycle
- WR_CHANNEL  in  CHANNEL_INDEX_WIDTH  target channel
- WR_WIDTH  in  WIDTH_BITS  requested pulse width, in ticks
- WR_ERROR  out  1  one-cycle pulse: accepted write had an invalid channel
- PWM_OUT  out  NUM_CHANNELS  registered servo pulses
- FRAME_START  out  1  one-cycle pulse at each frame commit
- FRAME_COUNT  out  WIDTH_BITS  current tick within the frame
- BUSY  out  1  high when state is not IDLE

Behaviour:
- Clocking and reset:
  - Single clock: SCHED_CLOCK.
  - SCHED_RESET_N is synchronous and active-low; it is sampled only on the SCHED_CLOCK rising edge.
  - On reset: state IDLE; prescaler = 0; FRAME_COUNT = 0; all shadow and active widths = DEFAULT_PULSE; PWM_OUT = 0; FRAME_START = 0; WR_ERROR = 0; BUSY = 0; WR_READY = 0.
  - WR_READY is 0 in the reset cycle and 1 from the first cycle after reset, except as noted below.
  - Reset mid-frame drops PWM_OUT to 0 on that edge. No partial pulse completes.
- Tick and frame counting:
  - Prescaler counts 0..TICK_DIVIDER-1 and emits an internal tick on its terminal count.
  - FRAME_COUNT increments on each tick and wraps FRAME_TICKS-1 -> 0.
  - A frame wrap is a tick that occurs while FRAME_COUNT = FRAME_TICKS-1.
  - Both counters are held at 0 in IDLE.
- State machine (IDLE, ALIGN, RUN, DRAIN):
  - IDLE: PWM_OUT = 0. SCHED_ENABLE = 1 moves to ALIGN.
  - ALIGN (exactly 1 cycle): active <= shadow for all channels; FRAME_START = 1; counters cleared; go to RUN.
  - RUN: at each frame wrap, active <= shadow and FRAME_START pulses for 1 cycle. SCHED_ENABLE = 0 moves to DRAIN.
  - DRAIN: PWM generation continues until the next frame wrap, then go to IDLE with no commit. SCHED_ENABLE = 1 during DRAIN returns to RUN with no frame disturbance.
- PWM generation:
  - PWM_OUT[i] <= (FRAME_COUNT < active[i]) in RUN and DRAIN; registered, so 1 cycle of latency from FRAME_COUNT.
- Write handshake:
  - A write is accepted when WR_VALID & WR_READY.
  - WR_READY = 0 in the ALIGN cycle and in the frame-wrap commit cycle; a pending WR_VALID must hold until accepted.
  - Width is clamped: below MIN_PULSE -> MIN_PULSE; above MAX_PULSE -> MAX_PULSE.
  - The shadow register updates on the accepting edge.
  - WR_CHANNEL >= NUM_CHANNELS: the write is accepted but discarded, and WR_ERROR pulses 1 cycle later.
  - Writes are accepted in every state, including IDLE.
  - A write accepted before a commit cycle is visible in that commit.
- Active widths never change outside ALIGN and the frame-wrap commit.

Optional Feature:
- Macro: SERVO_SCHED_STAGGER_EN.
- Defined: channel i's pulse starts at offset o = i*STAGGER_TICKS. PWM_OUT[i] is high while ((FRAME_COUNT - o) mod FRAME_TICKS) < active[i]. This spreads servo inrush current across the frame.
- Also when defined: elaboration fails if (NUM_CHANNELS-1)*STAGGER_TICKS + MAX_PULSE > FRAME_TICKS.
- Undefined: all channels start at FRAME_COUNT = 0, and STAGGER_TICKS is ignored.

Test Plan:
Bench parameters: TICK_DIVIDER=2, FRAME_TICKS=20, MIN_PULSE=3, MAX_PULSE=10, DEFAULT_PULSE=5, NUM_CHANNELS=4, STAGGER_TICKS=3.
1. Reset, then SCHED_ENABLE=1 -> ALIGN for 1 cycle, FRAME_START pulse; every PWM_OUT bit high for 5 ticks (10 cycles) per 20-tick frame.
2. Write ch1=8 at FRAME_COUNT=2 -> ch1 keeps width 5 for the current frame; ch1 width 8 from the next frame; FRAME_START pulses at the commit.
3. Write ch0=1 and ch2=50 -> widths clamp to 3 and 10; write to ch3 with WR_VALID held across the commit cycle -> WR_READY=0 on that cycle, write accepted on the next.
4. WR_CHANNEL=3 with NUM_CHANNELS=3 -> handshake completes, WR_ERROR pulses 1 cycle later, no channel's width changes.
5. SCHED_ENABLE=0 at FRAME_COUNT=7 -> DRAIN until the wrap, then IDLE with BUSY=0 and PWM_OUT=0; re-enable during DRAIN -> stays in RUN, no gap in the frame.
6. SCHED_RESET_N=0 at FRAME_COUNT=2 while pulses are high -> PWM_OUT=0 on the next edge, widths back to 5. With SERVO_SCHED_STAGGER_EN: ch2 rises at FRAME_COUNT=6.
